// File: rtl/router_pkg.sv
// Shared types and helpers for the router: buffer occupancy encoding, error counter width.
package router_pkg;

    localparam int ROUTER_ERR_NBITS = 16;

    // Skid-buffer occupancy doubles as its state encoding.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } router_cnt_t;

    function automatic int router_addr_nbits(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/router_skid_buf.sv
// Two-entry val/rdy FIFO used as a skid buffer in front of the router's output steering.
// Latency: 1 cycle enq to deq; sustains one transfer per cycle with simultaneous enq/deq.
// Backpressure: enq_rdy depends only on registered occupancy (low when FULL).
module router_skid_buf
    import router_pkg::*;
#(
    parameter int width = 34
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enq_val,
    output logic             enq_rdy,
    input  logic [width-1:0] enq_msg,
    output logic             deq_val,
    input  logic             deq_rdy,
    output logic [width-1:0] deq_msg,
    output router_cnt_t      count
);

    logic [width-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    router_cnt_t      state_q;
    router_cnt_t      state_d;
    logic             enq;
    logic             deq;

    assign enq_rdy = (state_q != FULL);
    assign deq_val = (state_q != EMPTY);
    assign deq_msg = mem[rd_ptr];
    assign count   = state_q;
    assign enq     = enq_val & enq_rdy;
    assign deq     = deq_val & deq_rdy;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (enq) state_d = ONE;
            ONE: begin
                if (enq && !deq)      state_d = FULL;
                else if (!enq && deq) state_d = EMPTY;
            end
            FULL:    if (deq) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (enq) wr_ptr <= ~wr_ptr;
            if (deq) rd_ptr <= ~rd_ptr;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (enq) mem[wr_ptr] <= enq_msg;
    end

endmodule

// File: rtl/router.sv
// Demuxes one {addr, payload} stream to per-port streams; ROUTER_ERR_CNT_EN adds err_cnt for invalid-address drops.
// Latency: 1 cycle accept-to-present, full throughput, strict in-order delivery.
// Backpressure: istream_rdy low only when the skid buffer is full; a stalled addressed port blocks all traffic.
module router
    import router_pkg::*;
#(
    parameter  int nbits      = 32,
    parameter  int noutputs   = 3,
    localparam int addr_nbits = router_addr_nbits(noutputs)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        istream_val,
    output logic                        istream_rdy,
    input  logic [addr_nbits+nbits-1:0] istream_msg,
    output logic                        ostream_val [noutputs],
    input  logic                        ostream_rdy [noutputs],
    output logic [nbits-1:0]            ostream_msg [noutputs]
`ifdef ROUTER_ERR_CNT_EN
    ,
    output logic [ROUTER_ERR_NBITS-1:0] err_cnt
`endif
);

    localparam int msg_nbits = addr_nbits + nbits;

    logic                  enq_rdy;
    logic                  deq_val;
    logic                  deq_rdy;
    logic [msg_nbits-1:0]  deq_msg;
    router_cnt_t           buf_count;
    logic [addr_nbits-1:0] h_addr;
    logic [31:0]           h_addr_w;
    logic                  addr_ok;
    logic                  sel_rdy;
    logic                  drop;

    router_skid_buf #(
        .width(msg_nbits)
    ) u_skid_buf (
        .clk     (clk),
        .reset   (reset),
        .enq_val (istream_val & ~reset),
        .enq_rdy (enq_rdy),
        .enq_msg (istream_msg),
        .deq_val (deq_val),
        .deq_rdy (deq_rdy),
        .deq_msg (deq_msg),
        .count   (buf_count)
    );

    assign istream_rdy = enq_rdy & ~reset;

    assign h_addr   = deq_msg[msg_nbits-1 -: addr_nbits];
    assign h_addr_w = 32'(h_addr);
    assign addr_ok  = (h_addr_w < 32'(noutputs));

    always_comb begin
        sel_rdy = 1'b0;
        for (int i = 0; i < noutputs; i++) begin
            ostream_val[i] = deq_val && (h_addr_w == 32'(i));
            ostream_msg[i] = deq_msg[nbits-1:0];
            if (h_addr_w == 32'(i)) sel_rdy = ostream_rdy[i];
        end
    end

    // Unroutable heads never wait on a port: they leave the buffer the cycle they arrive.
    assign drop    = deq_val & ~addr_ok;
    assign deq_rdy = addr_ok ? sel_rdy : 1'b1;

`ifdef ROUTER_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt <= '0;
        end else if (drop && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`else
    // Without the counter, invalid-address drops leave no trace.
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert ((buf_count != EMPTY) == deq_val);
        end
    end

endmodule

// File: tb/tb_router.sv
// Scenario tests for router with a scoreboard of expected {port, payload} deliveries.
module tb_router;

    localparam int NB = 32;
    localparam int NO = 3;

    typedef struct packed {
        logic [1:0]    port;
        logic [NB-1:0] data;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          istream_val;
    logic          istream_rdy;
    logic [NB+1:0] istream_msg;
    logic          ostream_val [NO];
    logic          ostream_rdy [NO];
    logic [NB-1:0] ostream_msg [NO];
`ifdef ROUTER_ERR_CNT_EN
    logic [15:0]   err_cnt;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    router #(.nbits(NB), .noutputs(NO)) dut (
        .clk         (clk),
        .reset       (reset),
        .istream_val (istream_val),
        .istream_rdy (istream_rdy),
        .istream_msg (istream_msg),
        .ostream_val (ostream_val),
        .ostream_rdy (ostream_rdy),
        .ostream_msg (ostream_msg)
`ifdef ROUTER_ERR_CNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every output handshake must match the oldest accepted valid-address message.
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NO; i++) begin
                if (ostream_val[i] && ostream_rdy[i]) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected: port %0d delivered %h, required no delivery", i, ostream_msg[i]);
                    end else begin
                        mon_e = sb.pop_front();
                        if (2'(i) !== mon_e.port || ostream_msg[i] !== mon_e.data) begin
                            errors++;
                            $display("FAIL sb_order: got port %0d msg %h, required port %0d msg %h",
                                     i, ostream_msg[i], mon_e.port, mon_e.data);
                        end
                    end
                end
            end
        end
    end

    task automatic set_all_rdy(input logic v);
        for (int i = 0; i < NO; i++) ostream_rdy[i] = v;
    endtask

    task automatic drive(input logic [1:0] addr, input logic [NB-1:0] data);
        istream_val = 1'b1;
        istream_msg = {addr, data};
    endtask

    task automatic idle(input int n);
        istream_val = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        set_all_rdy(1'b1);
        drive(2'd2, 32'h1111_1111);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (istream_rdy !== 1'b0) begin
            errors++;
            $display("FAIL reset_rdy: istream_rdy=%b, required 0", istream_rdy);
        end
        for (int i = 0; i < NO; i++) begin
            checks++;
            if (ostream_val[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_val%0d: ostream_val=%b, required 0", i, ostream_val[i]);
            end
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        istream_val = 1'b0;
        @(negedge clk);
        checks++;
        if (istream_rdy !== 1'b1 || ostream_val[0] !== 1'b0 || ostream_val[1] !== 1'b0 || ostream_val[2] !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: rdy=%b val=%b%b%b, required rdy=1 val=000",
                     istream_rdy, ostream_val[2], ostream_val[1], ostream_val[0]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_route;
        set_all_rdy(1'b1);
        drive(2'd2, 32'hDEAD_BEEF);
        @(negedge clk);
        if (istream_rdy) sb.push_back('{2'd2, 32'hDEAD_BEEF});
        @(posedge clk);
        #1;
        istream_val = 1'b0;
        @(negedge clk);
        checks++;
        if (ostream_val[2] !== 1'b1 || ostream_msg[2] !== 32'hDEAD_BEEF ||
            ostream_val[0] !== 1'b0 || ostream_val[1] !== 1'b0) begin
            errors++;
            $display("FAIL single_route: val=%b%b%b msg2=%h, required val=100 msg2=deadbeef",
                     ostream_val[2], ostream_val[1], ostream_val[0], ostream_msg[2]);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (ostream_val[2] !== 1'b0) begin
            errors++;
            $display("FAIL single_consumed: ostream_val[2]=%b, required 0", ostream_val[2]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        logic [1:0]    addrs [4];
        logic [NB-1:0] datas [4];
        addrs = '{2'd0, 2'd1, 2'd2, 2'd0};
        datas = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
        set_all_rdy(1'b1);
        for (int k = 0; k < 4; k++) begin
            drive(addrs[k], datas[k]);
            @(negedge clk);
            checks++;
            if (istream_rdy !== 1'b1) begin
                errors++;
                $display("FAIL stream_rdy%0d: istream_rdy=%b, required 1", k, istream_rdy);
            end else begin
                sb.push_back('{addrs[k], datas[k]});
            end
            if (k > 0) begin
                checks++;
                if (ostream_val[addrs[k-1]] !== 1'b1 || ostream_msg[addrs[k-1]] !== datas[k-1]) begin
                    errors++;
                    $display("FAIL stream_bubble%0d: val=%b msg=%h, required 1 %h",
                             k, ostream_val[addrs[k-1]], ostream_msg[addrs[k-1]], datas[k-1]);
                end
            end
            @(posedge clk);
            #1;
        end
        istream_val = 1'b0;
        @(negedge clk);
        checks++;
        if (ostream_val[0] !== 1'b1 || ostream_msg[0] !== datas[3]) begin
            errors++;
            $display("FAIL stream_last: val0=%b msg0=%h, required 1 %h", ostream_val[0], ostream_msg[0], datas[3]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure;
        set_all_rdy(1'b1);
        ostream_rdy[1] = 1'b0;
        drive(2'd1, 32'hB000_0000);
        @(negedge clk);
        checks++;
        if (istream_rdy !== 1'b1) begin
            errors++;
            $display("FAIL bp_first: istream_rdy=%b, required 1", istream_rdy);
        end else sb.push_back('{2'd1, 32'hB000_0000});
        @(posedge clk);
        #1;
        drive(2'd1, 32'hB000_0001);
        @(negedge clk);
        checks++;
        if (istream_rdy !== 1'b1) begin
            errors++;
            $display("FAIL bp_second: istream_rdy=%b, required 1", istream_rdy);
        end else sb.push_back('{2'd1, 32'hB000_0001});
        @(posedge clk);
        #1;
        drive(2'd1, 32'hB000_0002);
        @(negedge clk);
        checks++;
        if (istream_rdy !== 1'b0) begin
            errors++;
            $display("FAIL bp_full: istream_rdy=%b, required 0", istream_rdy);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (istream_rdy !== 1'b0 || ostream_val[1] !== 1'b1 || ostream_msg[1] !== 32'hB000_0000) begin
            errors++;
            $display("FAIL bp_hold: rdy=%b val1=%b msg1=%h, required 0 1 b0000000",
                     istream_rdy, ostream_val[1], ostream_msg[1]);
        end
        @(posedge clk);
        #1;
        ostream_rdy[1] = 1'b1;
        @(negedge clk);
        checks++;
        if (istream_rdy !== 1'b0) begin
            errors++;
            $display("FAIL bp_full_deq: istream_rdy=%b, required 0", istream_rdy);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (istream_rdy !== 1'b1 || ostream_msg[1] !== 32'hB000_0001) begin
            errors++;
            $display("FAIL bp_resume: rdy=%b msg1=%h, required 1 b0000001", istream_rdy, ostream_msg[1]);
        end
        if (istream_rdy) sb.push_back('{2'd1, 32'hB000_0002});
        @(posedge clk);
        #1;
        idle(3);
    endtask

    task automatic test_hol_blocking;
        set_all_rdy(1'b1);
        ostream_rdy[0] = 1'b0;
        drive(2'd0, 32'hC000_0000);
        @(negedge clk);
        if (istream_rdy) sb.push_back('{2'd0, 32'hC000_0000});
        @(posedge clk);
        #1;
        drive(2'd2, 32'hC000_0002);
        @(negedge clk);
        if (istream_rdy) sb.push_back('{2'd2, 32'hC000_0002});
        @(posedge clk);
        #1;
        istream_val = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (ostream_val[2] !== 1'b0 || ostream_val[0] !== 1'b1) begin
                errors++;
                $display("FAIL hol_block%0d: val0=%b val2=%b, required 1 0", k, ostream_val[0], ostream_val[2]);
            end
            @(posedge clk);
            #1;
        end
        ostream_rdy[0] = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (ostream_val[2] !== 1'b1 || ostream_msg[2] !== 32'hC000_0002) begin
            errors++;
            $display("FAIL hol_release: val2=%b msg2=%h, required 1 c0000002", ostream_val[2], ostream_msg[2]);
        end
        idle(2);
    endtask

    task automatic test_invalid_addr;
        set_all_rdy(1'b1);
        drive(2'd3, 32'hE000_0003);
        @(posedge clk);
        #1;
        drive(2'd0, 32'hE000_0000);
        @(negedge clk);
        checks++;
        if (ostream_val[0] !== 1'b0 || ostream_val[1] !== 1'b0 || ostream_val[2] !== 1'b0 || istream_rdy !== 1'b1) begin
            errors++;
            $display("FAIL invalid_noval: val=%b%b%b rdy=%b, required val=000 rdy=1",
                     ostream_val[2], ostream_val[1], ostream_val[0], istream_rdy);
        end
        if (istream_rdy) sb.push_back('{2'd0, 32'hE000_0000});
        @(posedge clk);
        #1;
        istream_val = 1'b0;
        @(negedge clk);
        checks++;
        if (ostream_val[0] !== 1'b1 || ostream_msg[0] !== 32'hE000_0000) begin
            errors++;
            $display("FAIL invalid_next: val0=%b msg0=%h, required 1 e0000000", ostream_val[0], ostream_msg[0]);
        end
`ifdef ROUTER_ERR_CNT_EN
        checks++;
        if (err_cnt !== 16'd1) begin
            errors++;
            $display("FAIL err_cnt: err_cnt=%0d, required 1", err_cnt);
        end
`endif
        idle(2);
    endtask

    task automatic test_reset_mid;
        set_all_rdy(1'b0);
        drive(2'd0, 32'hF000_0000);
        @(posedge clk);
        #1;
        drive(2'd1, 32'hF000_0001);
        @(posedge clk);
        #1;
        istream_val = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        reset = 1'b0;
        set_all_rdy(1'b1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (ostream_val[0] !== 1'b0 || ostream_val[1] !== 1'b0 || istream_rdy !== 1'b1) begin
                errors++;
                $display("FAIL reset_mid%0d: val0=%b val1=%b rdy=%b, required 0 0 1",
                         k, ostream_val[0], ostream_val[1], istream_rdy);
            end
            @(posedge clk);
            #1;
        end
`ifdef ROUTER_ERR_CNT_EN
        checks++;
        if (err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL err_cnt_reset: err_cnt=%0d, required 0", err_cnt);
        end
`endif
    endtask

    task automatic test_drain;
        int budget;
        budget = 0;
        while (sb.size() != 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d messages undelivered, required 0", sb.size());
        end
    endtask

    initial begin
        reset       = 1'b1;
        istream_val = 1'b0;
        istream_msg = '0;
        set_all_rdy(1'b1);
        test_reset();
        test_single_route();
        test_back_to_back();
        test_backpressure();
        test_hol_blocking();
        test_invalid_addr();
        test_drain();
        test_reset_mid();
        test_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/router.md
# router

Demultiplexing counterpart to the arbiter in `arbiter_router`. The router accepts one `{addr, payload}` stream, buffers it in a two-entry skid buffer, strips the address field and steers the payload to output port `addr`. It sits after the arbiter, or at the far end of a link fed by one, and restores the per-source streams. Delivery is in order, with one-cycle latency and full throughput.

## Interface
Parameters:
- `nbits`, 32, payload width.
- `noutputs`, 3, number of output streams (≥2).
- `addr_nbits`, `$clog2(noutputs)`, localparam, address field width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `istream_val`  in  1  input valid.
- `istream_rdy`  out  1  input ready.
- `istream_msg`  in  `addr_nbits+nbits`  `{addr, payload}`; `addr` is the MSBs.
- `ostream_val[noutputs]`  out  1 each  per-output valid.
- `ostream_rdy[noutputs]`  in  1 each  per-output ready.
- `ostream_msg[noutputs]`  out  `nbits` each  payload.
- `err_cnt`  out  16  dropped-message count (only with `ROUTER_ERR_CNT_EN`).

## Operation
- Buffer state, encoded by occupancy:
  - EMPTY (0), ONE (1), FULL (2).
  - Transitions: enq only → +1; deq only → −1; enq and deq together → unchanged.
- Enqueue: `istream_val & istream_rdy`.
- `istream_rdy = (count != 2)`. It is registered-state-derived and does not depend combinationally on any `ostream_rdy`.
- The head entry's address `h_addr` selects the target port:
  - `ostream_val[h_addr] = (count != 0)`.
  - All other `ostream_val` are 0.
  - Every `ostream_msg[i]` carries the head payload; it is valid only when that port's val is high.
- Dequeue (valid address): `ostream_val[h_addr] & ostream_rdy[h_addr]`.
- Invalid address (`h_addr >= noutputs`, possible only when `noutputs` is not a power of 2):
  - No `ostream_val` asserts.
  - The entry is dropped unconditionally in the cycle it reaches the head.
- Ordering is strict FIFO. Head-of-line blocking is intended: a stalled port blocks all traffic.
- The `ostream_rdy` of non-addressed ports is ignored.
- Reset:
  - count ← 0, so every `ostream_val` = 0.
  - `istream_rdy` = 0 during the reset cycle, then 1 in the first cycle after.
  - Buffered entries are discarded on reset mid-operation; storage contents are don't-care.

## Timing
- Latency: a message accepted at edge N is presented on its output from cycle N+1. There is no combinational `istream` → `ostream` path.
- Throughput: 1 message/cycle sustained while the addressed port holds `rdy` high.
- FULL with dequeue in the same cycle: `istream_rdy` is already 0, so there is no enqueue that cycle. The next cycle is in state ONE with `rdy` = 1.
- Bubble-free: in EMPTY or ONE, a simultaneous enqueue and dequeue keeps count constant.
- Output val and msg stay stable until the handshake completes.

## Configuration
- `ROUTER_ERR_CNT_EN` defined:
  - The `err_cnt` port exists.
  - It increments by 1 per invalid-address drop and saturates at 16'hFFFF.
  - Reset value is 0.
- Undefined:
  - The port and counter are absent.
  - Invalid-address entries are still dropped silently.

## Structure
- `router_pkg`:
  - `ROUTER_ERR_NBITS = 16`.
  - Function `router_addr_nbits(n)` returning `$clog2(n)`.
  - Typedef of the buffer count (2 bits).
- Sub-module `router_skid_buf`:
  - Generic 2-entry val/rdy FIFO of width `addr_nbits+nbits`.
  - Ports: `enq_val/rdy/msg`, `deq_val/rdy/msg`, `count`.
- The top level does address decode, `rdy` select, drop and `err_cnt`.

## Test plan
- Reset: assert `reset` with `istream_val` = 1 → all `ostream_val` = 0 and `istream_rdy` = 0. The cycle after deassertion, `istream_rdy` = 1 and count = 0.
- Single route: send `{2, 32'hDEADBEEF}` with all ports ready → next cycle `ostream_val[2]` = 1, `ostream_msg[2]` = DEADBEEF, others 0. It is consumed that cycle.
- Streaming: back-to-back addresses 0,1,2,0 with all `rdy` = 1 → one delivery per cycle, in order, no bubbles, `istream_rdy` held 1.
- Backpressure: `ostream_rdy[1]` = 0 while sending three messages to port 1 → first two accepted, `istream_rdy` = 0 after the second. Raising `rdy` drains both in order, and the third is then accepted.
- HOL blocking: head to port 0 (stalled), next to port 2 (ready) → `ostream_val[2]` stays 0 until port 0 handshakes.
- Invalid address (`ROUTER_ERR_CNT_EN`, `noutputs` = 3): send addr 3 → no `ostream_val`, entry dropped, `err_cnt` = 1. A following valid message is delivered one cycle later.
